// File: rtl/regfile_sb.sv
// Register file with write-through bypass on every read port, two prioritised
// write ports and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset_,
  input  logic                       we0_,
  input  logic [ADDR_W-1:0]          wr_addr0,
  input  logic [DATA_W-1:0]          wr_data0,
  input  logic                       we1_,
  input  logic [ADDR_W-1:0]          wr_addr1,
  input  logic [DATA_W-1:0]          wr_data1,
  input  logic                       rsv_,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       flush_,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  // Port 1 is the younger producer, so it is applied last and wins collisions.
  always_comb begin
    mem_d = mem_q;
    if (!we0_) mem_d[wr_addr0] = wr_data0;
    if (!we1_) mem_d[wr_addr1] = wr_data1;
    if (ZERO_REG != 0) mem_d[0] = '0;
  end

  // Reservation is applied after the write clears so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (!we0_) busy_d[wr_addr0] = 1'b0;
    if (!we1_) busy_d[wr_addr1] = 1'b0;
    if (!rsv_) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    if (!flush_) busy_d = '0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              hit0, hit1, busy;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit0 = !we0_ && (wr_addr0 == addr);
      assign hit1 = !we1_ && (wr_addr1 == addr);

      // Data is forced to zero while in reset so bypassed writes cannot leak out.
      always_comb begin
        data = mem_q[addr];
        if (hit0) data = wr_data0;
        if (hit1) data = wr_data1;
        if ((ZERO_REG != 0) && (addr == '0)) data = '0;
        if (!reset_) data = '0;
      end

      always_comb begin
        busy = busy_q[addr] && !hit0 && !hit1;
        if ((ZERO_REG != 0) && (addr == '0)) busy = 1'b0;
        if (!reset_) busy = 1'b0;
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi]                  = busy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one ZERO_REG=1 and one ZERO_REG=0 instance share stimulus.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          we0_ = 1'b1, we1_ = 1'b1, rsv_ = 1'b1, flush_ = 1'b1;
  logic [AW-1:0] wr_addr0 = '0, wr_addr1 = '0, rsv_addr = '0;
  logic [DW-1:0] wr_data0 = '0, wr_data1 = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data, rd_data_z0;
  logic [NR-1:0]    rd_busy, rd_busy_z0;
  logic [AW:0]      busy_cnt, busy_cnt_z0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset_(reset_), .we0_(we0_), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1_(we1_), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .rsv_(rsv_), .rsv_addr(rsv_addr),
    .flush_(flush_), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .reset_(reset_), .we0_(we0_), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1_(we1_), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .rsv_(rsv_), .rsv_addr(rsv_addr),
    .flush_(flush_), .rd_addr(rd_addr), .rd_data(rd_data_z0), .rd_busy(rd_busy_z0),
    .busy_cnt(busy_cnt_z0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("[TB] check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge and return all requests to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    we0_ = 1'b1; we1_ = 1'b1; rsv_ = 1'b1; flush_ = 1'b1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    // Reset: every address on every port reads zero and not busy.
    #2;
    for (int a = 0; a < (1 << AW); a++) begin
      set_rd(AW'(a), AW'((1 << AW) - 1 - a));
      #0.1;
      chk($sformatf("rst_rd0_a%0d", a), rd_data[0 +: DW], 32'h0);
      chk($sformatf("rst_rd1_a%0d", a), rd_data[DW +: DW], 32'h0);
      chk($sformatf("rst_busy_a%0d", a), {30'd0, rd_busy}, 32'h0);
    end
    chk("rst_busy_cnt", {26'd0, busy_cnt}, 32'h0);
    #1 reset_ = 1'b1;
    tick();

    // Bypass priority: port 1 wins in the same cycle and in the array.
    we0_ = 1'b0; wr_addr0 = 5'd5; wr_data0 = 32'h11111111;
    we1_ = 1'b0; wr_addr1 = 5'd5; wr_data1 = 32'h22222222;
    set_rd(5'd5, 5'd5);
    #1 chk("bypass_same_cycle", rd_data[0 +: DW], 32'h22222222);
    tick();
    #1 chk("bypass_array", rd_data[0 +: DW], 32'h22222222);
    chk("bypass_array_z0", rd_data_z0[DW +: DW], 32'h22222222);

    // Zero register: discarded for ZERO_REG=1, ordinary for ZERO_REG=0.
    we0_ = 1'b0; wr_addr0 = 5'd0; wr_data0 = 32'hDEADBEEF;
    rsv_ = 1'b0; rsv_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    #1 chk("zero_rd_same_cycle", rd_data[0 +: DW], 32'h0);
    chk("zero_busy_same_cycle", {31'd0, rd_busy[0]}, 32'h0);
    tick();
    #1 chk("zero_rd_after", rd_data[0 +: DW], 32'h0);
    chk("zero_busy_after", {31'd0, rd_busy[0]}, 32'h0);
    chk("zero_busy_cnt", {26'd0, busy_cnt}, 32'h0);
    chk("z0_rd_r0", rd_data_z0[0 +: DW], 32'hDEADBEEF);
    chk("z0_busy_r0", {31'd0, rd_busy_z0[0]}, 32'h1);
    chk("z0_busy_cnt", {26'd0, busy_cnt_z0}, 32'h1);
    flush_ = 1'b0;
    tick();
    #1 chk("z0_flush_cnt", {26'd0, busy_cnt_z0}, 32'h0);

    // Scoreboard: reservation visible one edge later, write clears immediately.
    rsv_ = 1'b0; rsv_addr = 5'd7;
    set_rd(5'd0, 5'd7);
    #1 chk("rsv_not_yet_visible", {31'd0, rd_busy[1]}, 32'h0);
    tick();
    #1 chk("rsv_busy_r7", {31'd0, rd_busy[1]}, 32'h1);
    chk("rsv_busy_cnt", {26'd0, busy_cnt}, 32'h1);
    tick();
    we0_ = 1'b0; wr_addr0 = 5'd7; wr_data0 = 32'h5A;
    #1 chk("wr_busy_drop", {31'd0, rd_busy[1]}, 32'h0);
    chk("wr_bypass_r7", rd_data[DW +: DW], 32'h5A);
    chk("wr_cnt_before_edge", {26'd0, busy_cnt}, 32'h1);
    tick();
    #1 chk("wr_cnt_after_edge", {26'd0, busy_cnt}, 32'h0);
    chk("wr_array_r7", rd_data[DW +: DW], 32'h5A);

    // Simultaneous reserve and write: new producer keeps the bit set.
    rsv_ = 1'b0; rsv_addr = 5'd3;
    tick();
    set_rd(5'd3, 5'd7);
    #1 chk("sim_pre_cnt", {26'd0, busy_cnt}, 32'h1);
    we1_ = 1'b0; wr_addr1 = 5'd3; wr_data1 = 32'h9;
    rsv_ = 1'b0; rsv_addr = 5'd3;
    tick();
    #1 chk("sim_busy_r3", {31'd0, rd_busy[0]}, 32'h1);
    chk("sim_data_r3", rd_data[0 +: DW], 32'h9);
    chk("sim_cnt", {26'd0, busy_cnt}, 32'h1);
    we0_ = 1'b0; wr_addr0 = 5'd3; wr_data0 = 32'h9;
    tick();
    #1 chk("sim_cleared_cnt", {26'd0, busy_cnt}, 32'h0);

    // Flush with a concurrent write, then asynchronous reset between edges.
    rsv_ = 1'b0; rsv_addr = 5'd1; tick();
    rsv_ = 1'b0; rsv_addr = 5'd2; tick();
    rsv_ = 1'b0; rsv_addr = 5'd4; tick();
    set_rd(5'd2, 5'd4);
    #1 chk("flush_pre_cnt", {26'd0, busy_cnt}, 32'h3);
    chk("flush_pre_busy", {30'd0, rd_busy}, 32'h3);
    flush_ = 1'b0;
    we0_ = 1'b0; wr_addr0 = 5'd2; wr_data0 = 32'h7;
    tick();
    #1 chk("flush_cnt", {26'd0, busy_cnt}, 32'h0);
    chk("flush_r2", rd_data[0 +: DW], 32'h7);
    chk("flush_busy", {30'd0, rd_busy}, 32'h0);
    rsv_ = 1'b0; rsv_addr = 5'd1;
    tick();
    #1 chk("rerv_cnt", {26'd0, busy_cnt}, 32'h1);
    reset_ = 1'b0;
    #1 chk("async_rst_cnt", {26'd0, busy_cnt}, 32'h0);
    chk("async_rst_r2", rd_data[0 +: DW], 32'h0);
    #2 reset_ = 1'b1;
    #1 chk("post_rst_array_r2", rd_data[0 +: DW], 32'h0);
    set_rd(5'd1, 5'd7);
    #1 chk("post_rst_busy_r1", {31'd0, rd_busy[0]}, 32'h0);
    chk("post_rst_array_r7", rd_data[DW +: DW], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with a built-in scoreboard, for the multi-issue pipeline. It provides NUM_RD combinational read ports with write-through bypass and two prioritised write ports. Per-register busy bits track outstanding producers so decode can stall on RAW hazards. It sits between decode (reads and reservations) and writeback (writes and busy clears).

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width; register count is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..8)
- ZERO_REG, 1, 1 = register 0 hard-wired to zero and never busy; 0 = register 0 is an ordinary register

- clk  in  1  clock, all state updates on rising edge
- reset_  in  1  asynchronous active-low reset
- we0_  in  1  write port 0 enable, active low
- wr_addr0  in  ADDR_W  write port 0 address
- wr_data0  in  DATA_W  write port 0 data
- we1_  in  1  write port 1 enable, active low; younger than port 0
- wr_addr1  in  ADDR_W  write port 1 address
- wr_data1  in  DATA_W  write port 1 data
- rsv_  in  1  reserve request, active low; marks rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- flush_  in  1  synchronous flush, active low; clears all busy bits
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- rd_busy  out  NUM_RD  per-port hazard flag, 1 = operand not yet available
- busy_cnt  out  ADDR_W+1  number of busy bits currently set

## Operation
- Storage: 2**ADDR_W entries of DATA_W, plus one busy bit per entry. With ZERO_REG=1, entry 0 has no storage and no busy bit.
- Read port k, purely combinational, in priority order:
  - ZERO_REG=1 and address 0 -> 0.
  - Port 1 enabled and wr_addr1 matches -> wr_data1.
  - Port 0 enabled and wr_addr0 matches -> wr_data0.
  - Otherwise -> array value.
- rd_busy[k] = busy_q[addr] and no enabled write port targets addr this cycle. It is always 0 for address 0 when ZERO_REG=1.
- A reservation made this cycle is not visible on rd_busy until the next cycle.
- Write: each enabled port updates its entry at the edge. If both ports target the same address, port 1's data is stored. With ZERO_REG=1, writes to 0 are discarded.
- Busy update at each edge, lowest priority first:
  - Clear bits for enabled write addresses.
  - Set the bit for rsv_addr if rsv_ is low.
  - flush_ low overrides both: all bits become 0. The register array still takes that cycle's writes.
- A reservation and a write to the same address in one cycle leave the bit set, because the new producer wins.
- Reserving an already-busy register leaves it busy. There is no producer count; the first write clears the bit.
- busy_cnt is a registered population count of busy bits, updated in the same edge as the bits. Maximum value is 2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG=1.
- reset_ low: all entries become 0, all busy bits 0, busy_cnt 0, immediately and independently of clk.

## Timing
- Read latency: 0 cycles, with a combinational path from addresses and write inputs to rd_data and rd_busy.
- Write latency: 1 edge; the value appears from the array in the cycle after the write and is bypassed in the same cycle.
- Busy set latency: 1 edge after rsv_. Clear is effectively 0 cycles, since rd_busy drops in the write cycle via the write match and busy_q clears at the edge.
- Outputs while reset_ is low: rd_data = 0 for all addresses, rd_busy = 0, busy_cnt = 0.
- Reset asserted mid-sequence discards all pending reservations and data. The first edge after release behaves as a normal cycle.
- No handshake back-pressure: every request is accepted every cycle.

## Test plan
- Reset then read: assert reset_, read all addresses on every port -> all rd_data 0, rd_busy 0, busy_cnt 0.
- Bypass priority:
  - Cycle 1: we0_ writes r5=0x11111111 and we1_ writes r5=0x22222222; rd_addr port0=5 -> rd_data 0x22222222 in the same cycle.
  - Cycle 2: r5 reads 0x22222222 from the array.
- Zero register: ZERO_REG=1, write r0=0xDEADBEEF and reserve r0 -> r0 reads 0, rd_busy 0, busy_cnt unchanged. With ZERO_REG=0 -> r0 reads 0xDEADBEEF.
- Scoreboard:
  - Reserve r7 -> the next cycle rd_busy=1 for r7 and busy_cnt=1.
  - Write r7=0x5A in a later cycle -> rd_busy=0 that cycle with data 0x5A, and busy_cnt=0 after the edge.
- Simultaneous reserve/write: r3 busy; in the same cycle write r3=0x9 and reserve r3 -> after the edge r3 is still busy, data reads 0x9, busy_cnt unchanged.
- Flush and async reset:
  - Reserve r1, r2, r4 -> busy_cnt=3.
  - flush_ together with a write r2=0x7 -> after the edge busy_cnt=0 and r2=0x7.
  - Re-reserve r1, then drop reset_ between edges -> busy_cnt and r2 become 0 immediately.
